// File: rtl/mspu_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package mspu_uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

   localparam logic [31:0] UART_ADDR            = 32'h1000_0000;
   localparam int          DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with a combinational head read; a push into a full FIFO is
// only taken when a pop frees the head slot on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 2 ** AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = count[AW];
   assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Fire-and-forget UART transmitter: buffers bytes stored by the core and
// sends them 8N1, LSB first; writes to a full buffer are dropped and flagged.
module uart_tx_fifo
   import mspu_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_AW      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        uart_dout,
   input  logic               uart_we,
   output logic               txd,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               fifo_full,
   output logic               overflow
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   uart_tx_state_t    state, state_n;
   logic [BAUD_W-1:0] baud_cnt, baud_n;
   logic [2:0]        bit_idx, bit_n;
   logic [7:0]        shift_reg, shift_n;
   logic              txd_n;
   logic              baud_last;
   logic              pop;
   logic              fifo_empty;
   logic [7:0]        fifo_dout;
   logic              unused_upper;

   assign unused_upper = ^uart_dout[31:8];

   sync_fifo #(
      .WIDTH (8),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (uart_we),
      .din   (uart_dout[7:0]),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign baud_last = (baud_cnt == BAUD_LAST);
   assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));
   assign busy      = (state != IDLE) || (fifo_count != '0);

   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      bit_n   = bit_idx;
      shift_n = shift_reg;
      case (state)
         IDLE: begin
            baud_n = '0;
            if (pop) begin
               state_n = START;
               shift_n = fifo_dout;
            end
         end
         START: begin
            baud_n = baud_cnt + 1'b1;
            if (baud_last) begin
               state_n = DATA;
               baud_n  = '0;
               bit_n   = '0;
            end
         end
         DATA: begin
            baud_n = baud_cnt + 1'b1;
            if (baud_last) begin
               baud_n = '0;
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_n   = bit_idx + 1'b1;
            end
         end
         STOP: begin
            baud_n = baud_cnt + 1'b1;
            if (baud_last) begin
               baud_n = '0;
               // Reload on the final stop cycle so frames run back to back.
               if (pop) begin
                  state_n = START;
                  shift_n = fifo_dout;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
            baud_n  = '0;
         end
      endcase

      // The line level is computed from the next state so it can be registered.
      case (state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = shift_n[bit_n];
         default: txd_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         txd       <= 1'b1;
         overflow  <= 1'b0;
      end else begin
         state     <= state_n;
         baud_cnt  <= baud_n;
         bit_idx   <= bit_n;
         shift_reg <= shift_n;
         txd       <= txd_n;
         if (uart_we && fifo_full && !pop) overflow <= 1'b1;
      end
   end

endmodule
